ext_burst_splitter: RTL and testbench

EXT_BURST_SPLITTER -- requirements
Module: ext_burst_splitter

---
 rtl/ext_burst_splitter.sv | 111 +++++++++++
 tb/tb_ext_burst_splitter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ext_burst_splitter.sv
// Splits one 1D transaction into bursts that never cross a MCHAN_BURST_LENGTH-aligned
// external address boundary; one burst is issued per downstream handshake.
module ext_burst_splitter #(
    parameter int TRANS_SID_WIDTH    = 1,
    parameter int TCDM_ADD_WIDTH     = 12,
    parameter int EXT_ADD_WIDTH      = 29,
    parameter int MCHAN_BURST_LENGTH = 64,
    parameter int MCHAN_OPC_WIDTH    = 4,
    parameter int MCHAN_LEN_WIDTH    = 15
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,

    input  logic                       mchan_req_i,
    output logic                       mchan_gnt_o,
    input  logic [TRANS_SID_WIDTH-1:0] mchan_sid_i,
    input  logic [MCHAN_OPC_WIDTH-1:0] mchan_opc_i,
    input  logic [MCHAN_LEN_WIDTH-1:0] mchan_len_i,
    input  logic                       mchan_inc_i,
    input  logic [TCDM_ADD_WIDTH-1:0]  mchan_tcdm_add_i,
    input  logic [EXT_ADD_WIDTH-1:0]   mchan_ext_add_i,

    output logic                       mchan_req_o,
    input  logic                       mchan_gnt_i,
    output logic [TRANS_SID_WIDTH-1:0] mchan_sid_o,
    output logic [MCHAN_OPC_WIDTH-1:0] mchan_opc_o,
    output logic [MCHAN_LEN_WIDTH-1:0] mchan_len_o,
    output logic                       mchan_inc_o,
    output logic [TCDM_ADD_WIDTH-1:0]  mchan_tcdm_add_o,
    output logic [EXT_ADD_WIDTH-1:0]   mchan_ext_add_o,
    output logic                       mchan_last_o
);

    localparam int BL_W = $clog2(MCHAN_BURST_LENGTH);
    localparam logic [BL_W:0]            BURST_LEN = (BL_W+1)'(MCHAN_BURST_LENGTH);
    localparam logic [MCHAN_LEN_WIDTH:0] LEN_ONE   = (MCHAN_LEN_WIDTH+1)'(1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    state_e                     state_q;
    logic [MCHAN_LEN_WIDTH:0]   rem_len_q;
    logic [EXT_ADD_WIDTH-1:0]   ext_add_q;
    logic [TCDM_ADD_WIDTH-1:0]  tcdm_add_q;
    logic [TRANS_SID_WIDTH-1:0] sid_q;
    logic [MCHAN_OPC_WIDTH-1:0] opc_q;
    logic                       inc_q;

    logic                       run;
    logic [BL_W:0]              room_b;
    logic [MCHAN_LEN_WIDTH:0]   room;
    logic [MCHAN_LEN_WIDTH:0]   cur_len;
    logic [MCHAN_LEN_WIDTH:0]   cur_len_m1;
    logic                       last;

    assign run        = (state_q == RUN);
    // Bytes left before the next aligned external boundary, 1..MCHAN_BURST_LENGTH.
    assign room_b     = BURST_LEN - {1'b0, ext_add_q[BL_W-1:0]};
    assign room       = (MCHAN_LEN_WIDTH+1)'(room_b);
    assign cur_len    = (rem_len_q < room) ? rem_len_q : room;
    assign cur_len_m1 = cur_len - LEN_ONE;
    assign last       = (rem_len_q <= cur_len);

    assign mchan_gnt_o      = (state_q == IDLE);
    assign mchan_req_o      = run;
    assign mchan_sid_o      = run ? sid_q : '0;
    assign mchan_opc_o      = run ? opc_q : '0;
    assign mchan_inc_o      = run ? inc_q : 1'b0;
    assign mchan_len_o      = run ? cur_len_m1[MCHAN_LEN_WIDTH-1:0] : '0;
    assign mchan_tcdm_add_o = run ? tcdm_add_q : '0;
    assign mchan_ext_add_o  = run ? ext_add_q : '0;
    assign mchan_last_o     = run ? last : 1'b0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            rem_len_q  <= '0;
            ext_add_q  <= '0;
            tcdm_add_q <= '0;
            sid_q      <= '0;
            opc_q      <= '0;
            inc_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mchan_req_i) begin
                        rem_len_q  <= {1'b0, mchan_len_i} + LEN_ONE;
                        ext_add_q  <= mchan_ext_add_i;
                        tcdm_add_q <= mchan_tcdm_add_i;
                        sid_q      <= mchan_sid_i;
                        opc_q      <= mchan_opc_i;
                        inc_q      <= mchan_inc_i;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    if (mchan_gnt_i) begin
                        if (last) begin
                            state_q <= IDLE;
                        end else begin
                            rem_len_q  <= rem_len_q - cur_len;
                            ext_add_q  <= ext_add_q + EXT_ADD_WIDTH'(cur_len);
                            tcdm_add_q <= tcdm_add_q + TCDM_ADD_WIDTH'(cur_len);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ext_burst_splitter.sv
// Directed bench for ext_burst_splitter: boundary splitting, stalls, wrap-around,
// mid-transaction reset and a maximum-length transaction.
module tb_ext_burst_splitter;

    localparam int SW = 1;
    localparam int TW = 12;
    localparam int EW = 29;
    localparam int OW = 2;
    localparam int LW = 15;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          req_i = 1'b0;
    logic          gnt_o;
    logic [SW-1:0] sid_i = '0;
    logic [OW-1:0] opc_i = '0;
    logic [LW-1:0] len_i = '0;
    logic          inc_i = 1'b0;
    logic [TW-1:0] tcdm_i = '0;
    logic [EW-1:0] ext_i = '0;
    logic          req_o;
    logic          gnt_i = 1'b0;
    logic [SW-1:0] sid_o;
    logic [OW-1:0] opc_o;
    logic [LW-1:0] len_o;
    logic          inc_o;
    logic [TW-1:0] tcdm_o;
    logic [EW-1:0] ext_o;
    logic          last_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ext_burst_splitter #(
        .TRANS_SID_WIDTH(SW), .TCDM_ADD_WIDTH(TW), .EXT_ADD_WIDTH(EW),
        .MCHAN_BURST_LENGTH(64), .MCHAN_OPC_WIDTH(OW), .MCHAN_LEN_WIDTH(LW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .mchan_req_i(req_i), .mchan_gnt_o(gnt_o), .mchan_sid_i(sid_i),
        .mchan_opc_i(opc_i), .mchan_len_i(len_i), .mchan_inc_i(inc_i),
        .mchan_tcdm_add_i(tcdm_i), .mchan_ext_add_i(ext_i),
        .mchan_req_o(req_o), .mchan_gnt_i(gnt_i), .mchan_sid_o(sid_o),
        .mchan_opc_o(opc_o), .mchan_len_o(len_o), .mchan_inc_o(inc_o),
        .mchan_tcdm_add_o(tcdm_o), .mchan_ext_add_o(ext_o), .mchan_last_o(last_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_gnt_o"}, 32'(gnt_o), 32'd1);
        chk({tag, "_req_o"}, 32'(req_o), 32'd0);
        chk({tag, "_data"}, {sid_o, opc_o, inc_o, last_o, 28'd0} | 32'(len_o), 32'd0);
        chk({tag, "_addr"}, 32'(ext_o) | 32'(tcdm_o), 32'd0);
    endtask

    task automatic send(input logic [SW-1:0] sid, input logic [OW-1:0] opc, input logic [LW-1:0] len,
                        input logic inc, input logic [TW-1:0] tcdm, input logic [EW-1:0] ext);
        chk("accept_gnt_o", 32'(gnt_o), 32'd1);
        req_i = 1'b1; sid_i = sid; opc_i = opc; len_i = len; inc_i = inc; tcdm_i = tcdm; ext_i = ext;
        step();
        req_i = 1'b0; sid_i = '0; opc_i = '0; len_i = '0; inc_i = 1'b0; tcdm_i = '0; ext_i = '0;
    endtask

    // Checks the presented burst in the current cycle; caller controls gnt_i.
    task automatic look(input string tag, input logic [EW-1:0] ext, input logic [TW-1:0] tcdm,
                        input logic [LW-1:0] len, input logic last,
                        input logic [SW-1:0] sid, input logic [OW-1:0] opc, input logic inc);
        $display("burst %s: ext=%0h tcdm=%0h len=%0d last=%0d", tag, ext_o, tcdm_o, len_o, last_o);
        chk({tag, "_req_o"}, 32'(req_o), 32'd1);
        chk({tag, "_gnt_o"}, 32'(gnt_o), 32'd0);
        chk({tag, "_ext"}, 32'(ext_o), 32'(ext));
        chk({tag, "_tcdm"}, 32'(tcdm_o), 32'(tcdm));
        chk({tag, "_len"}, 32'(len_o), 32'(len));
        chk({tag, "_last"}, 32'(last_o), 32'(last));
        chk({tag, "_attr"}, {29'd0, sid_o, opc_o, inc_o} , {29'd0, sid, opc, inc});
    endtask

    task automatic burst(input string tag, input logic [EW-1:0] ext, input logic [TW-1:0] tcdm,
                         input logic [LW-1:0] len, input logic last,
                         input logic [SW-1:0] sid, input logic [OW-1:0] opc, input logic inc);
        gnt_i = 1'b1;
        look(tag, ext, tcdm, len, last, sid, opc, inc);
        step();
    endtask

    initial begin
        // Reset state
        #2;
        check_idle("reset");
        #20;
        rst_ni = 1'b1;
        step();
        check_idle("post_reset");

        // Single aligned burst
        send(1'b1, 2'd2, 15'd63, 1'b1, 12'h000, 29'h100);
        burst("t23_b0", 29'h100, 12'h000, 15'd63, 1'b1, 1'b1, 2'd2, 1'b1);
        check_idle("t23_end");

        // Three bursts around 64-byte boundaries
        send(1'b0, 2'd1, 15'd99, 1'b1, 12'h010, 29'h130);
        burst("t24_b0", 29'h130, 12'h010, 15'd15, 1'b0, 1'b0, 2'd1, 1'b1);
        burst("t24_b1", 29'h140, 12'h020, 15'd63, 1'b0, 1'b0, 2'd1, 1'b1);
        burst("t24_b2", 29'h180, 12'h060, 15'd19, 1'b1, 1'b0, 2'd1, 1'b1);
        check_idle("t24_end");

        // Same with a 5-cycle stall before the second burst
        send(1'b1, 2'd3, 15'd99, 1'b0, 12'h010, 29'h130);
        burst("t25_b0", 29'h130, 12'h010, 15'd15, 1'b0, 1'b1, 2'd3, 1'b0);
        gnt_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            look("t25_stall", 29'h140, 12'h020, 15'd63, 1'b0, 1'b1, 2'd3, 1'b0);
            step();
        end
        burst("t25_b1", 29'h140, 12'h020, 15'd63, 1'b0, 1'b1, 2'd3, 1'b0);
        burst("t25_b2", 29'h180, 12'h060, 15'd19, 1'b1, 1'b1, 2'd3, 1'b0);
        check_idle("t25_end");

        // One byte right below a boundary
        send(1'b0, 2'd0, 15'd0, 1'b1, 12'h005, 29'h13F);
        burst("t26a_b0", 29'h13F, 12'h005, 15'd0, 1'b1, 1'b0, 2'd0, 1'b1);
        check_idle("t26a_end");

        // External address wrap-around
        send(1'b1, 2'd1, 15'd31, 1'b1, 12'hFF8, 29'h1FFFFFF0);
        burst("t26b_b0", 29'h1FFFFFF0, 12'hFF8, 15'd15, 1'b0, 1'b1, 2'd1, 1'b1);
        burst("t26b_b1", 29'h0000000, 12'h008, 15'd15, 1'b1, 1'b1, 2'd1, 1'b1);
        check_idle("t26b_end");

        // Reset pulse during the second burst aborts the transaction
        send(1'b0, 2'd1, 15'd99, 1'b1, 12'h010, 29'h130);
        burst("t27_b0", 29'h130, 12'h010, 15'd15, 1'b0, 1'b0, 2'd1, 1'b1);
        look("t27_b1", 29'h140, 12'h020, 15'd63, 1'b0, 1'b0, 2'd1, 1'b1);
        rst_ni = 1'b0;
        #1;
        check_idle("t27_in_reset");
        #3;
        rst_ni = 1'b1;
        step();
        check_idle("t27_after_release");
        step();
        check_idle("t27_no_burst");
        send(1'b1, 2'd2, 15'd63, 1'b0, 12'h040, 29'h200);
        burst("t27_new", 29'h200, 12'h040, 15'd63, 1'b1, 1'b1, 2'd2, 1'b0);
        check_idle("t27_end");

        // Maximum length: 512 back-to-back 64-byte bursts
        send(1'b0, 2'd3, 15'h7FFF, 1'b1, 12'h000, 29'h400);
        for (int i = 0; i < 512; i++) begin
            burst("t28", 29'h400 + 29'(i * 64), 12'(i * 64), 15'd63, (i == 511), 1'b0, 2'd3, 1'b1);
        end
        check_idle("t28_end");

        gnt_i = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
